// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs of the execute stage.
// The stage is the slave; the upstream pipeline (or a bench) is the master.
interface ex_stage_if;
  logic [0:7]  id_ex_control;
  logic [31:0] id_ex_signext;
  logic [31:0] id_ex_rdata1;
  logic [31:0] id_ex_rdata2;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic        wb_regwrite;
  logic [4:0]  wb_wreg;
  logic [31:0] wb_data;
  logic        stall;
  logic [0:3]  exmem_ctrl;
  logic [31:0] exmem_alu_out;
  logic [31:0] exmem_wdata;
  logic [4:0]  exmem_wreg;
  logic        exmem_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [1:0]  mul_state;

  // Upstream holds every ID/EX field stable for as long as stall is high.
  modport master (
    output id_ex_control, id_ex_signext, id_ex_rdata1, id_ex_rdata2,
    output id_ex_rs, id_ex_rt, id_ex_rd, wb_regwrite, wb_wreg, wb_data,
    input  stall, exmem_ctrl, exmem_alu_out, exmem_wdata, exmem_wreg,
    input  exmem_zero, hi_out, lo_out, mul_state
  );

  modport slave (
    input  id_ex_control, id_ex_signext, id_ex_rdata1, id_ex_rdata2,
    input  id_ex_rs, id_ex_rt, id_ex_rd, wb_regwrite, wb_wreg, wb_data,
    output stall, exmem_ctrl, exmem_alu_out, exmem_wdata, exmem_wreg,
    output exmem_zero, hi_out, lo_out, mul_state
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, EX/MEM register and an
// iterative shift-add HI/LO multiplier that stalls upstream while busy.
module ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} mul_state_t;

  mul_state_t  r_state;
  logic [0:3]  r_exmem_ctrl;
  logic [31:0] r_exmem_alu, r_exmem_wdata;
  logic [4:0]  r_exmem_wreg;
  logic        r_exmem_zero;
  logic [31:0] r_hi, r_lo;
  logic [63:0] r_mcand, r_acc;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_neg;

  logic [1:0]  w_aluop;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [31:0] w_fwd_a, w_fwd_b, w_op_b, w_result;
  logic [31:0] w_abs_a, w_abs_b;
  logic [63:0] w_acc_next;
  logic        w_is_mult, w_signed, w_stall, w_bubble;

  assign w_aluop = bus.id_ex_control[3:4];
  assign w_funct = bus.id_ex_signext[5:0];
  assign w_shamt = bus.id_ex_signext[10:6];

  // EX/MEM wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    w_fwd_a = bus.id_ex_rdata1;
    w_fwd_b = bus.id_ex_rdata2;
    if (FWD_EN) begin
      if (r_exmem_ctrl[0] && r_exmem_wreg != 5'd0 && r_exmem_wreg == bus.id_ex_rs)
        w_fwd_a = r_exmem_alu;
      else if (bus.wb_regwrite && bus.wb_wreg != 5'd0 && bus.wb_wreg == bus.id_ex_rs)
        w_fwd_a = bus.wb_data;
      if (r_exmem_ctrl[0] && r_exmem_wreg != 5'd0 && r_exmem_wreg == bus.id_ex_rt)
        w_fwd_b = r_exmem_alu;
      else if (bus.wb_regwrite && bus.wb_wreg != 5'd0 && bus.wb_wreg == bus.id_ex_rt)
        w_fwd_b = bus.wb_data;
    end
  end

  assign w_op_b = bus.id_ex_control[2] ? bus.id_ex_signext : w_fwd_b;

  always_comb begin
    w_result = 32'd0;
    case (w_aluop)
      2'b00: w_result = w_fwd_a + w_op_b;
      2'b01: w_result = w_fwd_a - w_op_b;
      2'b11: w_result = w_fwd_a | {16'd0, bus.id_ex_signext[15:0]};
      default: begin
        case (w_funct)
          F_ADD, F_ADDU: w_result = w_fwd_a + w_op_b;
          F_SUB, F_SUBU: w_result = w_fwd_a - w_op_b;
          F_AND:  w_result = w_fwd_a & w_op_b;
          F_OR:   w_result = w_fwd_a | w_op_b;
          F_XOR:  w_result = w_fwd_a ^ w_op_b;
          F_NOR:  w_result = ~(w_fwd_a | w_op_b);
          F_SLT:  w_result = {31'd0, $signed(w_fwd_a) < $signed(w_op_b)};
          F_SLTU: w_result = {31'd0, w_fwd_a < w_op_b};
          F_SLL:  w_result = w_fwd_b << w_shamt;
          F_SRL:  w_result = w_fwd_b >> w_shamt;
          F_SRA:  w_result = $unsigned($signed(w_fwd_b) >>> w_shamt);
          F_MFHI: w_result = r_hi;
          F_MFLO: w_result = r_lo;
          default: w_result = 32'd0;
        endcase
      end
    endcase
  end

  assign w_is_mult  = (w_aluop == 2'b10) && (w_funct == F_MULT || w_funct == F_MULTU);
  assign w_signed   = (w_funct == F_MULT);
  assign w_abs_a    = (w_signed && w_fwd_a[31]) ? (32'd0 - w_fwd_a) : w_fwd_a;
  assign w_abs_b    = (w_signed && w_op_b[31])  ? (32'd0 - w_op_b)  : w_op_b;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'd0);

  // The mult sits in EX from the IDLE cycle through DONE; all of it is bubbled.
  assign w_stall  = !rst && ((r_state == S_IDLE && w_is_mult) || r_state == S_BUSY);
  assign w_bubble = w_stall || r_state == S_DONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_exmem_ctrl  <= 4'd0;
      r_exmem_alu   <= 32'd0;
      r_exmem_wdata <= 32'd0;
      r_exmem_wreg  <= 5'd0;
      r_exmem_zero  <= 1'b0;
      r_hi          <= 32'd0;
      r_lo          <= 32'd0;
      r_mcand       <= 64'd0;
      r_acc         <= 64'd0;
      r_mplier      <= 32'd0;
      r_cnt         <= 5'd0;
      r_neg         <= 1'b0;
    end else begin
      if (w_bubble) begin
        r_exmem_ctrl  <= 4'd0;
        r_exmem_alu   <= 32'd0;
        r_exmem_wdata <= 32'd0;
        r_exmem_wreg  <= 5'd0;
        r_exmem_zero  <= 1'b0;
      end else begin
        r_exmem_ctrl  <= {bus.id_ex_control[1], bus.id_ex_control[5],
                          bus.id_ex_control[6], bus.id_ex_control[7]};
        r_exmem_alu   <= w_result;
        r_exmem_wdata <= w_fwd_b;
        r_exmem_wreg  <= bus.id_ex_control[0] ? bus.id_ex_rd : bus.id_ex_rt;
        r_exmem_zero  <= (w_result == 32'd0);
      end
      case (r_state)
        S_IDLE: begin
          if (w_is_mult) begin
            r_mcand  <= {32'd0, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_neg    <= w_signed && (w_fwd_a[31] ^ w_op_b[31]);
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            {r_hi, r_lo} <= r_neg ? (64'd0 - w_acc_next) : w_acc_next;
            r_state      <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall         = w_stall;
  assign bus.exmem_ctrl    = r_exmem_ctrl;
  assign bus.exmem_alu_out = r_exmem_alu;
  assign bus.exmem_wdata   = r_exmem_wdata;
  assign bus.exmem_wreg    = r_exmem_wreg;
  assign bus.exmem_zero    = r_exmem_zero;
  assign bus.hi_out        = r_hi;
  assign bus.lo_out        = r_lo;
  assign bus.mul_state     = r_state;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboarded ALU/forwarding traffic,
// multiply timing and bubbles, and reset during a multiply.
module tb_ex_stage;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [73:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  ex_stage_if bus ();
  ex_stage #(.FWD_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [73:0] pk(input logic [3:0] c, input logic [31:0] alu,
                                     input logic [31:0] wd, input logic [4:0] wr);
    return {c, alu, wd, wr, (alu == 32'd0)};
  endfunction

  function automatic logic [73:0] dut_out();
    logic [3:0] c;
    c = bus.exmem_ctrl;
    return {c, bus.exmem_alu_out, bus.exmem_wdata, bus.exmem_wreg, bus.exmem_zero};
  endfunction

  function automatic logic [31:0] ref_rtype(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return $unsigned($signed(b) >>> sh);
      6'h10: return exp_hi;
      6'h12: return exp_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic [7:0] ctrl, input logic [31:0] imm,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.id_ex_control = ctrl;
    bus.id_ex_signext = imm;
    bus.id_ex_rdata1  = rd1;
    bus.id_ex_rdata2  = rd2;
    bus.id_ex_rs      = rs;
    bus.id_ex_rt      = rt;
    bus.id_ex_rd      = rd;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] wr, input logic [31:0] d);
    bus.wb_regwrite = we;
    bus.wb_wreg     = wr;
    bus.wb_data     = d;
  endtask

  // Drive one instruction, push its expected EX/MEM contents, then pop and compare
  // once the register has captured it.
  task automatic issue(input string tag, input logic [7:0] ctrl, input logic [31:0] imm,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [73:0] exp);
    set_id(ctrl, imm, rd1, rd2, rs, rt, rd);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), {6'd0, dut_out()}, {6'd0, exp_q.pop_front()});
  endtask

  // Run one multiply from its first EX cycle through DONE, checking timing and bubbles.
  task automatic run_mult(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic regw, input logic [63:0] prod);
    int  n_stall;
    bit  done;
    set_id({1'b1, regw, 1'b0, 2'b10, 3'b000}, {26'd0, f}, a, b, 5'd1, 5'd2, 5'd7);
    #1;
    check({tag, "_stall_T"}, {79'd0, bus.stall}, 80'd1);
    n_stall = 1;
    done    = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_bubble"}, {6'd0, dut_out()}, 80'd0);
      if (bus.stall) n_stall++;
      else done = 1'b1;
    end
    check({tag, "_stall_len"}, 80'(n_stall), 80'd33);
    check({tag, "_state_done"}, {78'd0, bus.mul_state}, 80'd2);
    check({tag, "_hi"}, {48'd0, bus.hi_out}, {48'd0, prod[63:32]});
    check({tag, "_lo"}, {48'd0, bus.lo_out}, {48'd0, prod[31:0]});
    exp_hi = prod[63:32];
    exp_lo = prod[31:0];
    @(posedge clk);
    #1;
    check({tag, "_done_bubble"}, {6'd0, dut_out()}, 80'd0);
    check({tag, "_state_idle"}, {78'd0, bus.mul_state}, 80'd0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [7:0] C_RW  = 8'b11010000;  // R-type, writes rd
  localparam logic [7:0] C_RNW = 8'b10010000;  // R-type, no GPR write

  logic [5:0] funct_tab [14];

  initial begin
    logic [31:0] a, b, r;
    logic [4:0]  sh, rdn;
    logic [5:0]  f;
    funct_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                  6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F};

    rst = 1'b1;
    set_id(8'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {79'd0, bus.stall}, 80'd0);
    check("rst_exmem", {6'd0, dut_out()}, 80'd0);
    check("rst_hi", {48'd0, bus.hi_out}, 80'd0);
    check("rst_lo", {48'd0, bus.lo_out}, 80'd0);
    check("rst_state", {78'd0, bus.mul_state}, 80'd0);
    rst = 1'b0;

    // ALU basics
    issue("add_5_7",   C_RW, 32'h20, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, pk(4'b1000, 32'd12, 32'd7, 5'd3));
    issue("sub_7_7",   C_RW, 32'h22, 32'd7, 32'd7, 5'd1, 5'd2, 5'd3, pk(4'b1000, 32'd0, 32'd7, 5'd3));
    issue("slt_m1_1",  C_RW, 32'h2A, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd2, 5'd3, pk(4'b1000, 32'd1, 32'd1, 5'd3));
    issue("sltu_m1_1", C_RW, 32'h2B, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd2, 5'd3, pk(4'b1000, 32'd0, 32'd1, 5'd3));
    issue("beq_sub",   8'b00001000, 32'd0, 32'd9, 32'd9, 5'd1, 5'd2, 5'd3, pk(4'b0000, 32'd0, 32'd9, 5'd2));

    // Forwarding priority and r0 exclusion
    issue("fw_prod", C_RW, 32'h20, 32'hAA, 32'd0, 5'd1, 5'd2, 5'd4, pk(4'b1000, 32'hAA, 32'd0, 5'd4));
    set_wb(1'b1, 5'd4, 32'hBB);
    issue("fw_exmem", C_RNW, 32'h20, 32'h11, 32'd0, 5'd4, 5'd2, 5'd9, pk(4'b0000, 32'hAA, 32'd0, 5'd9));
    issue("fw_wb",    C_RNW, 32'h20, 32'h11, 32'd0, 5'd4, 5'd2, 5'd9, pk(4'b0000, 32'hBB, 32'd0, 5'd9));
    set_wb(1'b0, 5'd0, 32'd0);
    issue("r0_prod", C_RW, 32'h20, 32'h55, 32'd0, 5'd1, 5'd2, 5'd0, pk(4'b1000, 32'h55, 32'd0, 5'd0));
    set_wb(1'b1, 5'd0, 32'h55);
    issue("r0_nofwd", C_RNW, 32'h20, 32'd7, 32'd3, 5'd0, 5'd0, 5'd9, pk(4'b0000, 32'd10, 32'd3, 5'd9));
    set_wb(1'b0, 5'd0, 32'd0);

    // Immediate paths
    issue("sw_prod", C_RW, 32'h20, 32'h1234, 32'd0, 5'd1, 5'd2, 5'd5, pk(4'b1000, 32'h1234, 32'd0, 5'd5));
    issue("sw_fwd_rt", 8'b00100100, 32'd8, 32'h100, 32'hDEAD, 5'd6, 5'd5, 5'd0, pk(4'b0100, 32'h108, 32'h1234, 5'd5));
    issue("ori_zext",  8'b01111000, 32'hFFFF8001, 32'hF0F0, 32'd0, 5'd1, 5'd6, 5'd0, pk(4'b1000, 32'hF0F1, 32'd0, 5'd6));
    issue("lw_negoff", 8'b01100011, 32'hFFFFFFFC, 32'h200, 32'd0, 5'd1, 5'd7, 5'd0, pk(4'b1011, 32'h1FC, 32'd0, 5'd7));

    // Multiplies and HI/LO reads
    run_mult("mult", 6'h18, 32'hFFFFFFFD, 32'd5, 1'b0, 64'hFFFFFFFF_FFFFFFF1);
    issue("mflo", C_RW, 32'h12, 32'd0, 32'd0, 5'd0, 5'd0, 5'd8, pk(4'b1000, exp_lo, 32'd0, 5'd8));
    issue("mfhi", C_RW, 32'h10, 32'd0, 32'd0, 5'd0, 5'd0, 5'd8, pk(4'b1000, exp_hi, 32'd0, 5'd8));
    run_mult("multu", 6'h19, 32'hFFFFFFFF, 32'd2, 1'b1, 64'h00000001_FFFFFFFE);
    issue("mfhi_u", C_RW, 32'h10, 32'd0, 32'd0, 5'd0, 5'd0, 5'd8, pk(4'b1000, 32'd1, 32'd0, 5'd8));

    // Random R-type traffic, no GPR writes so nothing forwards
    for (int i = 0; i < 16; i++) begin
      f   = funct_tab[$urandom_range(0, 13)];
      a   = $urandom;
      b   = $urandom;
      sh  = 5'($urandom_range(0, 31));
      rdn = 5'($urandom_range(1, 31));
      r   = ref_rtype(f, a, b, sh);
      issue($sformatf("rnd_f%0h", f), C_RNW, {21'd0, sh, f}, a, b, 5'd1, 5'd2, rdn,
            pk(4'b0000, r, b, rdn));
    end

    // Reset in the middle of a multiply
    set_id({1'b1, 1'b0, 1'b0, 2'b10, 3'b000}, 32'h18, 32'd1234, 32'd77, 5'd1, 5'd2, 5'd7);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_busy", {79'd0, bus.stall}, 80'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_stall", {79'd0, bus.stall}, 80'd0);
    check("midrst_hi", {48'd0, bus.hi_out}, 80'd0);
    check("midrst_lo", {48'd0, bus.lo_out}, 80'd0);
    check("midrst_state", {78'd0, bus.mul_state}, 80'd0);
    check("midrst_exmem", {6'd0, dut_out()}, 80'd0);
    set_id(8'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    rst = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    issue("post_rst_mfhi", C_RW, 32'h10, 32'd0, 32'd0, 5'd0, 5'd0, 5'd8, pk(4'b1000, 32'd0, 32'd0, 5'd8));
    issue("post_rst_nostall", C_RW, 32'h21, 32'd3, 32'd4, 5'd1, 5'd2, 5'd9, pk(4'b1000, 32'd7, 32'd4, 5'd9));

    // ---------------- report ----------------
    check("queue_drained", 80'(exp_q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
